// File: rtl/uart_rx.sv
// 8N1 UART receiver: 4x oversampling, two-flop input synchroniser, one-cycle
// byte / framing-error strobes feeding the hex command parser.
module uart_rx #(
    parameter int CLK_DIV = 108
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_byte_en,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       rx_busy
);
    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;

    state_t       state, state_nxt;
    logic         rx_m, rx_s;
    logic [DW-1:0] div_cnt;
    logic         tick;
    logic [1:0]   phase, phase_nxt;
    logic [2:0]   bitcnt, bitcnt_nxt;
    logic [7:0]   shreg, shreg_nxt, byte_nxt;
    logic         en_nxt, err_nxt;

    assign tick = (div_cnt == DW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            div_cnt    <= '0;
            phase      <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            rx_byte_en <= 1'b0;
            frame_err  <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            rx_m       <= rx;
            rx_s       <= rx_m;
            div_cnt    <= tick ? '0 : div_cnt + DW'(1);
            phase      <= phase_nxt;
            bitcnt     <= bitcnt_nxt;
            shreg      <= shreg_nxt;
            rx_byte    <= byte_nxt;
            rx_byte_en <= en_nxt;
            frame_err  <= err_nxt;
            rx_busy    <= (state != IDLE);
        end
    end

    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        bitcnt_nxt = bitcnt;
        shreg_nxt  = shreg;
        byte_nxt   = rx_byte;
        en_nxt     = 1'b0;
        err_nxt    = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_nxt = START;
                        phase_nxt = 2'd0;
                    end
                end
                START: begin
                    // Second look at the start bit near mid-bit filters glitches.
                    if (phase == 2'd0) begin
                        phase_nxt = 2'd1;
                    end else if (!rx_s) begin
                        state_nxt  = DATA;
                        phase_nxt  = 2'd0;
                        bitcnt_nxt = 3'd0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                DATA: begin
                    phase_nxt = phase + 2'd1;
                    if (phase == 2'd3) begin
                        shreg_nxt  = {rx_s, shreg[7:1]};
                        bitcnt_nxt = bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            state_nxt = STOP;
                            phase_nxt = 2'd0;
                        end
                    end
                end
                STOP: begin
                    phase_nxt = phase + 2'd1;
                    if (phase == 2'd3) begin
                        if (rx_s) begin
                            byte_nxt  = shreg;
                            en_nxt    = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = WAITHI;
                        end
                    end
                end
                WAITHI: begin
                    // Hold here through a break so it is not decoded as 0x00 frames.
                    if (rx_s) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLK_DIV=4 (16 clk per bit): frame table plus
// hand sequences for glitch, break, back-to-back and mid-frame reset.
`timescale 1ns/100ps
module tb_uart_rx;
    localparam int CLK_DIV = 4;
    localparam int BIT_NS  = 160;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx_byte_en;
    logic [7:0] rx_byte;
    logic       frame_err;
    logic       rx_busy;

    always #5 clk = ~clk;

    uart_rx #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .rx_byte_en(rx_byte_en), .rx_byte(rx_byte),
        .frame_err(frame_err), .rx_busy(rx_busy)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] got_q[$];
    int got_t[$];
    int ferr_cnt = 0;
    int both_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_byte_en) begin
            got_q.push_back(rx_byte);
            got_t.push_back(cyc);
        end
        if (frame_err) ferr_cnt++;
        if (rx_byte_en && frame_err) both_cnt++;
    end

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       stop;
        int         bit_ns;
        int         exp_cnt;
        logic [7:0] exp_byte;
        int         exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #2.5;
    endtask

    task automatic clear_mon();
        got_q.delete();
        got_t.delete();
        ferr_cnt = 0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int bit_ns);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(bit_ns);
        end
        rx = stop;
        #(bit_ns);
    endtask

    task automatic rx_one(input string name, input logic [7:0] d);
        align();
        clear_mon();
        send_frame(d, 1'b1, BIT_NS);
        rx = 1'b1;
        #(3 * BIT_NS);
        check({name, "_cnt"}, got_q.size(), 1);
        if (got_q.size() > 0) check({name, "_byte"}, got_q[0], d);
        check({name, "_ferr"}, ferr_cnt, 0);
    endtask

    initial begin
        vecs[0] = '{"byte41",    8'h41, 1'b1, 160, 1, 8'h41, 0};
        vecs[1] = '{"byte55",    8'h55, 1'b1, 160, 1, 8'h55, 0};
        vecs[2] = '{"fast00",    8'h00, 1'b1, 157, 1, 8'h00, 0};
        vecs[3] = '{"fastFF",    8'hFF, 1'b1, 157, 1, 8'hFF, 0};
        vecs[4] = '{"slow00",    8'h00, 1'b1, 163, 1, 8'h00, 0};
        vecs[5] = '{"slowFF",    8'hFF, 1'b1, 163, 1, 8'hFF, 0};
        vecs[6] = '{"badstopA5", 8'hA5, 1'b0, 160, 0, 8'h00, 1};
        vecs[7] = '{"byte0D",    8'h0D, 1'b1, 160, 1, 8'h0D, 0};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_en", rx_byte_en, 0);
        check("reset_ferr", frame_err, 0);
        check("reset_byte", rx_byte, 8'h00);
        check("reset_busy", rx_busy, 0);
        rst = 1'b0;
        repeat (8) @(posedge clk);

        for (int k = 0; k < 8; k++) begin
            align();
            clear_mon();
            send_frame(vecs[k].data, vecs[k].stop, vecs[k].bit_ns);
            rx = 1'b1;
            #(3 * vecs[k].bit_ns);
            check({vecs[k].name, "_cnt"}, got_q.size(), vecs[k].exp_cnt);
            if (vecs[k].exp_cnt == 1 && got_q.size() > 0)
                check({vecs[k].name, "_byte"}, got_q[0], vecs[k].exp_byte);
            check({vecs[k].name, "_ferr"}, ferr_cnt, vecs[k].exp_err);
            check({vecs[k].name, "_busy"}, rx_busy, 0);
        end

        // Back-to-back "3A\r", no idle between frames.
        align();
        clear_mon();
        send_frame(8'h33, 1'b1, BIT_NS);
        send_frame(8'h41, 1'b1, BIT_NS);
        send_frame(8'h0D, 1'b1, BIT_NS);
        rx = 1'b1;
        #(3 * BIT_NS);
        check("b2b_cnt", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("b2b_byte0", got_q[0], 8'h33);
            check("b2b_byte1", got_q[1], 8'h41);
            check("b2b_byte2", got_q[2], 8'h0D);
            check("b2b_gap01_ok", int'((got_t[1] - got_t[0]) >= 156 && (got_t[1] - got_t[0]) <= 164), 1);
            check("b2b_gap12_ok", int'((got_t[2] - got_t[1]) >= 156 && (got_t[2] - got_t[1]) <= 164), 1);
        end
        check("b2b_ferr", ferr_cnt, 0);

        // Glitch: 3 clk low pulse.
        align();
        clear_mon();
        rx = 1'b0;
        #30;
        rx = 1'b1;
        #(4 * BIT_NS);
        check("glitch_cnt", got_q.size(), 0);
        check("glitch_ferr", ferr_cnt, 0);
        check("glitch_busy", rx_busy, 0);
        rx_one("after_glitch55", 8'h55);

        // Framing error followed by a 40-bit break.
        align();
        clear_mon();
        send_frame(8'hA5, 1'b0, BIT_NS);
        #(40 * BIT_NS);
        check("break_ferr", ferr_cnt, 1);
        check("break_cnt", got_q.size(), 0);
        check("break_busy", rx_busy, 1);
        rx = 1'b1;
        #(3 * BIT_NS);
        check("break_release_busy", rx_busy, 0);
        check("break_ferr_total", ferr_cnt, 1);
        rx_one("after_break0A", 8'h0A);

        // Reset pulse during data bit 4 of 0xFF.
        align();
        clear_mon();
        fork
            send_frame(8'hFF, 1'b1, BIT_NS);
            begin
                #(5 * BIT_NS + 80);
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_mid_byte", rx_byte, 8'h00);
                check("rst_mid_busy", rx_busy, 0);
            end
        join
        rx = 1'b1;
        #(3 * BIT_NS);
        check("rst_mid_cnt", got_q.size(), 0);
        check("rst_mid_ferr", ferr_cnt, 0);
        rx_one("after_rst30", 8'h30);

        check("en_err_overlap", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
